// File: rtl/io_bus_master_pkg.sv
// Shared I/O bus definitions: port address map, bus direction codes and the
// bus master FSM state encoding.
package io_bus_master_pkg;

    localparam int IO_A0        = 0;
    localparam int IO_D0        = 1;
    localparam int IO_D1        = 2;
    localparam int IO_D2        = 3;
    localparam int IO_D3        = 4;
    localparam int IO_NUM_PORTS = 5;

    localparam logic IO_WRITE = 1'b1;
    localparam logic IO_READ  = 1'b0;

    // state  | meaning
    // IDLE   | waiting for a core request; bus registers hold last transaction
    // SETUP  | address/direction driven, en low, setup counter running
    // ACCESS | single en strobe; read data captured on the closing edge
    // DONE   | one-cycle done pulse, err valid
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } bus_state_e;

endpackage

// File: rtl/io_bus_master.sv
// Initiator side of the CPU I/O bus: turns a single IN/OUT request into a
// timed bus cycle (setup, one-cycle en strobe, read capture, done pulse).
module io_bus_master
    import io_bus_master_pkg::*;
#(
    parameter int BITS         = 16,
    parameter int ADDR_W       = 4,
    parameter int NUM_PORTS    = IO_NUM_PORTS,
    parameter int SETUP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BITS-1:0]   req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [BITS-1:0]   rdata,
    output logic              io_en,
    output logic              io_rw,
    output logic [ADDR_W-1:0] io_addr,
    output logic [BITS-1:0]   io_wdata,
    input  logic [BITS-1:0]   io_rdata
);

    localparam logic [3:0]      SETUP_LD  = 4'(SETUP_CYCLES);
    localparam logic [ADDR_W:0] NUM_P_EXT = (ADDR_W+1)'(NUM_PORTS);

    bus_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              io_rw_q, io_rw_d;
    logic [ADDR_W-1:0] io_addr_q, io_addr_d;
    logic [BITS-1:0]   io_wdata_q, io_wdata_d;
    logic [BITS-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              addr_ok;

    assign addr_ok = ({1'b0, req_addr} < NUM_P_EXT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            io_rw_q    <= 1'b0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            io_rw_q    <= io_rw_d;
            io_addr_q  <= io_addr_d;
            io_wdata_q <= io_wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        io_rw_d    = io_rw_q;
        io_addr_d  = io_addr_q;
        io_wdata_d = io_wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    io_rw_d    = req_we;
                    io_addr_d  = req_addr;
                    io_wdata_d = req_wdata;
                    err_d      = ~addr_ok;
                    if (!addr_ok) begin
                        state_d = ST_DONE;
                    end else if (SETUP_LD == 4'd0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LD;
                    end
                end
            end
            ST_SETUP: begin
                // <= 1 rather than == 1 so a corrupted count can never stall here
                if (cnt_q <= 4'd1) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                if (io_rw_q == IO_READ) begin
                    rdata_d = io_rdata;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state register so async reset kills them at once.
    assign io_en    = (state_q == ST_ACCESS);
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign err      = err_q & (state_q == ST_DONE);
    assign io_rw    = io_rw_q;
    assign io_addr  = io_addr_q;
    assign io_wdata = io_wdata_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_io_bus_master.sv
// Bench for io_bus_master: three instances (setup 0, 1, 3) driven from a vector
// table plus hand sequences; a negedge monitor checks against a scoreboard queue.
module tb_io_bus_master;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic        err;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;

    typedef struct {
        int          k;
        logic        we;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rd;
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst      [3];
    logic        req      [3];
    logic        req_we   [3];
    logic [3:0]  req_addr [3];
    logic [15:0] req_wdata[3];
    logic        busy     [3];
    logic        done     [3];
    logic        err      [3];
    logic [15:0] rdata    [3];
    logic        io_en    [3];
    logic        io_rw    [3];
    logic [3:0]  io_addr  [3];
    logic [15:0] io_wdata [3];
    logic [15:0] io_rdata [3];
    logic [15:0] rdsrc    [3];

    exp_t sb[3][$];
    int   en_cnt[3];
    int   cyc   = 0;
    int   nvec  = 0;
    int   nerr  = 0;
    vec_t vecs[12];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int SCG = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        assign io_rdata[g] = (io_en[g] && !io_rw[g]) ? rdsrc[g] : 16'hDEAD;
        io_bus_master #(.SETUP_CYCLES(SCG)) u_dut (
            .clk      (clk),
            .rst      (rst[g]),
            .req      (req[g]),
            .req_we   (req_we[g]),
            .req_addr (req_addr[g]),
            .req_wdata(req_wdata[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .err      (err[g]),
            .rdata    (rdata[g]),
            .io_en    (io_en[g]),
            .io_rw    (io_rw[g]),
            .io_addr  (io_addr[g]),
            .io_wdata (io_wdata[g]),
            .io_rdata (io_rdata[g])
        );
    end

    function automatic int sc_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d: got %0h, required %0h", nm, k, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst[k]) begin
                en_cnt[k] = 0;
            end else begin
                if (busy[k] && sb[k].size() > 0) begin
                    mon_e = sb[k][0];
                    chk("bus_stable", k, 64'({io_rw[k], io_addr[k], io_wdata[k]}),
                        64'({mon_e.we, mon_e.addr, mon_e.wdata}));
                end
                if (io_en[k]) begin
                    en_cnt[k]++;
                    if (sb[k].size() == 0) begin
                        chk("en_unexpected", k, 64'(1), 64'(0));
                    end else begin
                        mon_e = sb[k][0];
                        chk("en_on_err", k, 64'(mon_e.err), 64'(0));
                        chk("en_timing", k, 64'(cyc - mon_e.cyc), 64'(1 + sc_of(k)));
                    end
                end
                if (done[k]) begin
                    if (sb[k].size() == 0) begin
                        chk("done_unexpected", k, 64'(1), 64'(0));
                    end else begin
                        mon_e = sb[k].pop_front();
                        chk("done_latency", k, 64'(cyc - mon_e.cyc),
                            64'(mon_e.err ? 1 : 2 + sc_of(k)));
                        chk("err", k, 64'(err[k]), 64'(mon_e.err));
                        chk("rdata", k, 64'(rdata[k]), 64'(mon_e.rdata));
                        chk("en_pulses", k, 64'(en_cnt[k]), 64'(mon_e.err ? 0 : 1));
                    end
                    en_cnt[k] = 0;
                end
            end
        end
    end

    task automatic push_exp(input int k, input logic we, input logic [3:0] addr,
                            input logic [15:0] wdata, input logic e_err,
                            input logic [15:0] e_rdata, input int c);
        exp_t e;
        e.we = we; e.addr = addr; e.wdata = wdata;
        e.err = e_err; e.rdata = e_rdata; e.cyc = c;
        sb[k].push_back(e);
    endtask

    // One-cycle request; inputs scrambled afterwards since they must only be sampled in IDLE.
    task automatic issue(input int k, input logic we, input logic [3:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rd,
                         input logic e_err, input logic [15:0] e_rdata);
        @(posedge clk); #1;
        req[k] = 1'b1; req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata;
        rdsrc[k] = rd;
        push_exp(k, we, addr, wdata, e_err, e_rdata, cyc);
        @(posedge clk); #1;
        req[k] = 1'b0;
        req_we[k] = 1'($urandom);
        req_addr[k] = 4'($urandom);
        req_wdata[k] = 16'($urandom);
    endtask

    task automatic wait_idle(input int k);
        for (int i = 0; i < 60 && sb[k].size() != 0; i++) @(posedge clk);
        chk("completion_timeout", k, 64'(sb[k].size()), 64'(0));
        sb[k].delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1, 1'b1, 4'h0, 16'h1234, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = '{1, 1'b0, 4'h3, 16'h0000, 16'h0001, 1'b0, 16'h0001};
        vecs[2]  = '{1, 1'b0, 4'h9, 16'h0000, 16'hBEEF, 1'b1, 16'h0001};
        vecs[3]  = '{1, 1'b1, 4'h4, 16'hABCD, 16'h5555, 1'b0, 16'h0001};
        vecs[4]  = '{1, 1'b0, 4'h4, 16'h0000, 16'hA5A5, 1'b0, 16'hA5A5};
        vecs[5]  = '{1, 1'b0, 4'h5, 16'h0000, 16'h1111, 1'b1, 16'hA5A5};
        vecs[6]  = '{0, 1'b0, 4'h1, 16'h0000, 16'h0F0F, 1'b0, 16'h0F0F};
        vecs[7]  = '{0, 1'b1, 4'h2, 16'hFFFF, 16'h0000, 1'b0, 16'h0F0F};
        vecs[8]  = '{0, 1'b0, 4'hF, 16'h0000, 16'h2222, 1'b1, 16'h0F0F};
        vecs[9]  = '{2, 1'b1, 4'h1, 16'h00FF, 16'h0000, 1'b0, 16'h0000};
        vecs[10] = '{2, 1'b0, 4'h0, 16'h0000, 16'hC3C3, 1'b0, 16'hC3C3};
        vecs[11] = '{2, 1'b0, 4'h4, 16'h0000, 16'h7777, 1'b0, 16'h7777};

        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; req_we[k] = 1'b0;
            req_addr[k] = 4'h0; req_wdata[k] = 16'h0; rdsrc[k] = 16'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++)
            chk("reset_state", k,
                64'({io_en[k], io_rw[k], io_addr[k], io_wdata[k], rdata[k], busy[k], done[k], err[k]}),
                64'(0));
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;

        for (int v = 0; v < 12; v++) begin
            issue(vecs[v].k, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].rd,
                  vecs[v].exp_err, vecs[v].exp_rdata);
            wait_idle(vecs[v].k);
        end

        // Request pulsed while busy must be dropped, not queued.
        issue(2, 1'b0, 4'h2, 16'h0000, 16'h4321, 1'b0, 16'h4321);
        req[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 4'h0; req_wdata[2] = 16'hFFFF;
        @(posedge clk); #1;
        req[2] = 1'b0;
        wait_idle(2);
        repeat (8) @(posedge clk);

        // Held request: back-to-back transactions separated by one IDLE cycle.
        @(posedge clk); #1;
        req[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 4'h2; req_wdata[1] = 16'h5A5A;
        push_exp(1, 1'b1, 4'h2, 16'h5A5A, 1'b0, 16'hA5A5, cyc);
        push_exp(1, 1'b1, 4'h2, 16'h5A5A, 1'b0, 16'hA5A5, cyc + 4);
        repeat (4) @(posedge clk);
        #1;
        chk("b2b_idle_gap", 1, 64'(busy[1]), 64'(0));
        @(posedge clk); #1;
        req[1] = 1'b0;
        chk("b2b_restart", 1, 64'(busy[1]), 64'(1));
        wait_idle(1);

        // Reset during ACCESS: strobes drop without a clock edge.
        issue(2, 1'b1, 4'h1, 16'h0BAD, 16'h0000, 1'b0, 16'h4321);
        for (int i = 0; i < 10 && !io_en[2]; i++) begin
            @(posedge clk); #1;
        end
        chk("reach_access", 2, 64'(io_en[2]), 64'(1));
        #2;
        rst[2] = 1'b1;
        sb[2].delete();
        #1;
        chk("rst_async_strobes", 2, 64'({io_en[2], busy[2], done[2]}), 64'(0));
        chk("rst_async_rdata", 2, 64'(rdata[2]), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst[2] = 1'b0;
        #1;
        chk("rst_release_idle", 2, 64'({busy[2], io_en[2], io_addr[2]}), 64'(0));
        @(posedge clk); #1;
        chk("rst_stay_idle", 2, 64'(busy[2]), 64'(0));
        issue(2, 1'b0, 4'h3, 16'h0000, 16'h9999, 1'b0, 16'h9999);
        wait_idle(2);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
